alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and helpers for the ALU arbiter
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b1000;
    localparam logic [7:0] ERR_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESPOND
    } state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector starting after last_grant
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        logic            found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_id    = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one registered ALU among NUM_REQ requesters, one op in flight
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0][7:0] req_a,
    input  logic [NUM_REQ-1:0][7:0] req_b,
    input  logic [NUM_REQ-1:0][3:0] req_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [7:0]              rsp_data,
    output logic                    rsp_carry,
    output logic                    rsp_err,
    output logic [7:0]              alu_a,
    output logic [7:0]              alu_b,
    output logic [3:0]              alu_sel,
    input  logic [7:0]              alu_out,
    input  logic                    alu_carry
);

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [1:0]         rst_sync;
    logic               armed;
    logic               win;
    logic [7:0]         win_a;
    logic [7:0]         win_b;
    logic [3:0]         win_sel;
    logic               win_bad;

    // Reset asserts at once but releases two edges later, so IDLE never grants off a raw deassertion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign armed = rst_sync[1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign req_ready = (state == ST_IDLE && armed) ? grant : '0;
    assign win       = |req_ready;
    assign win_a     = req_a[grant_id];
    assign win_b     = req_b[grant_id];
    assign win_sel   = req_sel[grant_id];
    assign win_bad   = !is_onehot(win_sel) || (win_sel == OP_DIV && win_b == 8'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win) begin
                        last_grant <= grant_id;
                        rsp_id     <= grant_id;
                        if (win_bad) begin
                            // Rejected ops never touch the ALU registers.
                            rsp_data  <= ERR_DATA;
                            rsp_carry <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESPOND;
                        end else begin
                            alu_a   <= win_a;
                            alu_b   <= win_b;
                            alu_sel <= win_sel;
                            rsp_err <= 1'b0;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_data  <= alu_out;
                    rsp_carry <= (alu_sel == OP_ADD) && alu_carry;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0][7:0] req_a;
    logic [N-1:0][7:0] req_b;
    logic [N-1:0][3:0] req_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [7:0]        rsp_data;
    logic              rsp_carry;
    logic              rsp_err;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [3:0]        alu_sel;
    logic [7:0]        alu_out;
    logic              alu_carry;
    logic              div0_seen = 1'b0;

    always #5 clock = ~clock;

    alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    // External registered ALU; also watches for a divide-by-zero ever reaching it.
    always_ff @(posedge clock) begin
        alu_carry <= 1'b0;
        case (alu_sel)
            4'b0001: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
            4'b0010: alu_out <= alu_a - alu_b;
            4'b0100: alu_out <= alu_a * alu_b;
            4'b1000: alu_out <= (alu_b == 8'd0) ? 8'h00 : alu_a / alu_b;
            default: alu_out <= 8'h00;
        endcase
        if (alu_sel == 4'b1000 && alu_b == 8'd0) begin
            div0_seen <= 1'b1;
        end
    end

    int checks   = 0;
    int failures = 0;

    // Model: busy flag plus cycles until the response shows, derived from the op's latency.
    bit         m_busy;
    int         m_cnt;
    int         m_last;
    int         m_arm;
    int         exp_gid;
    logic [1:0] m_id;
    logic [7:0] m_data;
    logic       m_carry;
    logic       m_err;
    logic [7:0] cap_a;
    logic [7:0] cap_b;
    logic [3:0] cap_sel;

    logic       s_valid;
    logic [N-1:0] s_ready;
    int         s_gid;
    logic [1:0] s_id;
    logic [7:0] s_data;
    logic       s_carry;
    logic       s_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_op(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] sel);
        int x;
        logic [9:0] res;
        res = {1'b1, 1'b0, 8'hFF};
        x   = 0;
        case (sel)
            4'b0001: begin
                x   = int'(a) + int'(b);
                res = {1'b0, (x > 255), 8'(x % 256)};
            end
            4'b0010: begin
                x   = (int'(a) - int'(b) + 256) % 256;
                res = {2'b00, 8'(x)};
            end
            4'b0100: begin
                x   = int'(a) * int'(b);
                res = {2'b00, 8'(x % 256)};
            end
            4'b1000: begin
                if (b != 8'd0) res = {2'b00, 8'(int'(a) / int'(b))};
            end
            default: ;
        endcase
        return res;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_cnt   = 0;
        m_last  = N - 1;
        m_arm   = 0;
        exp_gid = -1;
    endtask

    task automatic check();
        logic [N-1:0] er;
        int g;
        g  = -1;
        er = '0;
        if (reset_n && !m_busy && m_arm >= 2) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            end
        end
        exp_gid = g;
        if (g >= 0) begin
            er[g]   = 1'b1;
            cap_a   = req_a[g];
            cap_b   = req_b[g];
            cap_sel = req_sel[g];
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_cnt == 0));
        if (m_busy && m_cnt == 0) begin
            chk("rsp_fields", 32'({rsp_id, rsp_data, rsp_carry, rsp_err}),
                32'({m_id, m_data, m_carry, m_err}));
        end
        s_valid = rsp_valid;
        s_ready = req_ready;
        s_id    = rsp_id;
        s_data  = rsp_data;
        s_carry = rsp_carry;
        s_err   = rsp_err;
        s_gid   = -1;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) s_gid = i;
        end
    endtask

    task automatic model_advance();
        logic [9:0] r;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (exp_gid >= 0) begin
            r       = model_op(cap_a, cap_b, cap_sel);
            m_last  = exp_gid;
            m_id    = 2'(exp_gid);
            m_err   = r[9];
            m_carry = r[8];
            m_data  = r[7:0];
            m_busy  = 1'b1;
            m_cnt   = m_err ? 0 : 2;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                if (rsp_ready) m_busy = 1'b0;
            end else begin
                m_cnt--;
            end
        end
        if (m_arm < 2) m_arm++;
    endtask

    // Called at posedge+1 with this cycle's inputs driven; returns at the next posedge+1.
    task automatic step();
        @(negedge clock);
        check();
        @(posedge clock);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("reset_rsp_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err}), 32'd0);
        chk("reset_alu_outputs", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, output int lat);
        int n;
        req_valid     = '0;
        req_valid[id] = 1'b1;
        req_a[id]     = a;
        req_b[id]     = b;
        req_sel[id]   = sel;
        rsp_ready     = 1'b0;
        n = 0;
        while (n < 10) begin
            step();
            n++;
            if (s_ready != '0) break;
        end
        chk("grant_seen", 32'(s_ready), 32'(1) << id);
        req_valid = '0;
        lat = 0;
        while (lat < 10) begin
            step();
            lat++;
            if (s_valid) break;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int ng;
        int order [5];
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        chk("por_rsp_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err}), 32'd0);
        chk("por_alu_outputs", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        issue(0, 8'd200, 8'd100, 4'b0001, lat);
        chk("add_latency", 32'(lat), 32'd3);
        chk("add_result", 32'({s_id, s_data, s_carry, s_err}), 32'({2'd0, 8'd44, 1'b1, 1'b0}));
        finish_rsp();

        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i]   = 8'(i * 10);
            req_b[i]   = 8'd1;
            req_sel[i] = 4'b0001;
        end
        for (int i = 0; i < 5; i++) order[i] = -1;
        req_valid = '1;
        rsp_ready = 1'b1;
        ng = 0;
        n  = 0;
        while (ng < 5 && n < 60) begin
            step();
            n++;
            if (s_gid >= 0) begin
                order[ng] = s_gid;
                ng++;
            end
        end
        chk("rr_grant_count", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++) chk("rr_order", 32'(order[i]), 32'(i % 4));
        req_valid = '0;
        repeat (6) step();
        rsp_ready = 1'b0;

        issue(2, 8'd9, 8'd0, 4'b1000, lat);
        chk("div0_latency", 32'(lat), 32'd1);
        chk("div0_result", 32'({s_id, s_data, s_carry, s_err}), 32'({2'd2, 8'hFF, 1'b0, 1'b1}));
        finish_rsp();

        issue(1, 8'h33, 8'h44, 4'b0110, lat);
        chk("badsel_latency", 32'(lat), 32'd1);
        chk("badsel_result", 32'({s_id, s_data, s_carry, s_err}), 32'({2'd1, 8'hFF, 1'b0, 1'b1}));
        finish_rsp();

        issue(1, 8'd16, 8'd17, 4'b0100, lat);
        chk("mul_latency", 32'(lat), 32'd3);
        chk("mul_result", 32'({s_data, s_carry, s_err}), 32'({8'h10, 1'b0, 1'b0}));
        finish_rsp();

        issue(0, 8'd5, 8'd7, 4'b0010, lat);
        chk("sub_latency", 32'(lat), 32'd3);
        req_valid = '1;
        repeat (5) begin
            step();
            chk("hold_rsp", 32'({s_valid, s_data, s_err}), 32'({1'b1, 8'hFE, 1'b0}));
            chk("hold_no_ready", 32'(s_ready), 32'd0);
        end
        req_valid = '0;
        finish_rsp();

        // Reset in CAPTURE: handshake, one ISSUE cycle, then pull reset.
        req_valid    = 4'b1000;
        req_a[3]     = 8'hA5;
        req_b[3]     = 8'h5A;
        req_sel[3]   = 4'b0001;
        n = 0;
        while (n < 10) begin
            step();
            n++;
            if (s_ready != '0) break;
        end
        chk("capture_grant", 32'(s_ready), 32'h8);
        req_valid = '0;
        step();
        do_reset();
        repeat (4) begin
            step();
            chk("no_rsp_after_reset", 32'(s_valid), 32'd0);
        end
        req_valid = '1;
        for (int i = 0; i < N; i++) req_sel[i] = 4'b0001;
        n = 0;
        while (n < 10) begin
            step();
            n++;
            if (s_gid >= 0) break;
        end
        chk("first_grant_after_reset", 32'(s_gid), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();

        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            req_valid = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                int r;
                r        = int'($urandom_range(0, 9));
                req_a[i] = 8'($urandom);
                req_b[i] = 8'($urandom);
                if (r < 7) begin
                    req_sel[i] = 4'(1 << $urandom_range(0, 3));
                end else if (r == 7) begin
                    req_sel[i] = 4'($urandom);
                end else begin
                    req_sel[i] = 4'b1000;
                    req_b[i]   = 8'd0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        chk("div0_never_issued", 32'(div0_seen), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
